// File: rtl/sd_cmd_framer_if.sv
// Bundle between the SD command framer, the init/read sequencer and the SPI byte shifter.
// The master modport is the framer's view of the bundle; the slave modport is the other end.
interface sd_cmd_framer_if;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        busy;
    logic        done;
    logic [7:0]  r1;
    logic        timeout;
    logic        cs_n;
    logic        spi_tx_valid;
    logic [7:0]  spi_tx_byte;
    logic        spi_byte_done;
    logic [7:0]  spi_rx_byte;
    logic        spi_idle;

    modport master (
        input  cmd_start, cmd_index, cmd_arg, spi_byte_done, spi_rx_byte, spi_idle,
        output busy, done, r1, timeout, cs_n, spi_tx_valid, spi_tx_byte
    );
    modport slave (
        output cmd_start, cmd_index, cmd_arg, spi_byte_done, spi_rx_byte, spi_idle,
        input  busy, done, r1, timeout, cs_n, spi_tx_valid, spi_tx_byte
    );
endinterface

// File: rtl/sd_cmd_framer.sv
// SD SPI-mode command engine: sends lead 0xFF bytes, a 6-byte CRC7 frame, polls for R1,
// sends one trailing 0xFF and releases chip-select once the shifter is idle.
module sd_cmd_framer #(
    parameter int LEAD_FF  = 1,
    parameter int MAX_POLL = 8
) (
    input  logic            clock,
    input  logic            reset,
    sd_cmd_framer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_FRAME, S_POLL, S_TRAIL, S_DRAIN, S_FIN} state_t;

    localparam logic [7:0] LEAD_LAST = 8'((LEAD_FF > 0) ? LEAD_FF - 1 : 0);
    localparam logic [7:0] POLL_LAST = 8'(MAX_POLL - 1);

    state_t      r_state, w_state;
    logic [47:0] r_frame, w_frame;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_busy, w_busy, r_done, w_done, r_timeout, w_timeout;
    logic        r_cs_n, w_cs_n, r_tx_valid, w_tx_valid;
    logic [7:0]  r_r1, w_r1, r_tx_byte, w_tx_byte;
    logic [7:0]  w_b0;
    logic [47:0] w_new_frame;

    // Bit-serial CRC7 (x^7 + x^3 + 1), MSB first, zero seed.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign w_b0        = {2'b01, bus.cmd_index};
    assign w_new_frame = {w_b0, bus.cmd_arg, crc7({w_b0, bus.cmd_arg}), 1'b1};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_r1       <= 8'hFF;
            r_timeout  <= 1'b0;
            r_cs_n     <= 1'b1;
            r_tx_valid <= 1'b0;
            r_tx_byte  <= 8'hFF;
        end else begin
            r_state    <= w_state;
            r_frame    <= w_frame;
            r_cnt      <= w_cnt;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_r1       <= w_r1;
            r_timeout  <= w_timeout;
            r_cs_n     <= w_cs_n;
            r_tx_valid <= w_tx_valid;
            r_tx_byte  <= w_tx_byte;
        end
    end

    // The head of r_frame is always the next frame byte to hand to the shifter.
    always_comb begin
        w_state    = r_state;
        w_frame    = r_frame;
        w_cnt      = r_cnt;
        w_busy     = r_busy;
        w_done     = r_done;
        w_r1       = r_r1;
        w_timeout  = r_timeout;
        w_cs_n     = r_cs_n;
        w_tx_valid = r_tx_valid;
        w_tx_byte  = r_tx_byte;
        case (r_state)
            S_IDLE: if (bus.cmd_start) begin
                w_busy     = 1'b1;
                w_cs_n     = 1'b0;
                w_tx_valid = 1'b1;
                w_cnt      = '0;
                if (LEAD_FF > 0) begin
                    w_frame   = w_new_frame;
                    w_tx_byte = 8'hFF;
                    w_state   = S_LEAD;
                end else begin
                    w_frame   = {w_new_frame[39:0], 8'h00};
                    w_tx_byte = w_new_frame[47:40];
                    w_state   = S_FRAME;
                end
            end
            S_LEAD: if (bus.spi_byte_done) begin
                if (r_cnt == LEAD_LAST) begin
                    w_tx_byte = r_frame[47:40];
                    w_frame   = {r_frame[39:0], 8'h00};
                    w_cnt     = '0;
                    w_state   = S_FRAME;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            S_FRAME: if (bus.spi_byte_done) begin
                if (r_cnt == 8'd5) begin
                    w_tx_byte = 8'hFF;
                    w_cnt     = '0;
                    w_state   = S_POLL;
                end else begin
                    w_tx_byte = r_frame[47:40];
                    w_frame   = {r_frame[39:0], 8'h00};
                    w_cnt     = r_cnt + 8'd1;
                end
            end
            S_POLL: if (bus.spi_byte_done) begin
                if (!bus.spi_rx_byte[7]) begin
                    w_r1      = bus.spi_rx_byte;
                    w_timeout = 1'b0;
                    w_state   = S_TRAIL;
                end else if (r_cnt >= POLL_LAST) begin
                    w_r1      = 8'hFF;
                    w_timeout = 1'b1;
                    w_state   = S_TRAIL;
                end else if (r_cnt != 8'hFF) begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            S_TRAIL: if (bus.spi_byte_done) begin
                w_tx_valid = 1'b0;
                w_state    = S_DRAIN;
            end
            S_DRAIN: if (bus.spi_idle) begin
                w_cs_n  = 1'b1;
                w_done  = 1'b1;
                w_state = S_FIN;
            end
            S_FIN: begin
                w_done  = 1'b0;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.r1           = r_r1;
    assign bus.timeout      = r_timeout;
    assign bus.cs_n         = r_cs_n;
    assign bus.spi_tx_valid = r_tx_valid;
    assign bus.spi_tx_byte  = r_tx_byte;
endmodule

// File: tb/tb_sd_cmd_framer.sv
// Bench for sd_cmd_framer: behavioural SPI shifter, CRC7 by polynomial division,
// directed vector table, hand-written abort/ignore sequences and random commands.
module tb_sd_cmd_framer;
    localparam int LEAD  = 1;
    localparam int MAXP  = 8;
    localparam int SHIFT = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    sd_cmd_framer_if bus();
    sd_cmd_framer #(.LEAD_FF(LEAD), .MAX_POLL(MAXP)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    int checks = 0, failures = 0;
    logic [7:0] txq[$];
    int k = 0;
    int resp_delay = -1;
    logic [7:0] resp_val = 8'h01;
    int done_cnt = 0, cs_viol = 0;
    logic prev_cs = 1'b1, pe_idle = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC7 as remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc_ref(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'b0};
        for (int b = 46; b >= 7; b--)
            if (v[b]) v = v ^ (47'h89 << (b - 7));
        return v[6:0];
    endfunction

    // Frame bytes answer 00 so any leak into r1 is visible; poll byte `resp_delay` carries R1.
    function automatic logic [7:0] rx_for(input int idx);
        int p;
        p = idx - (LEAD + 6);
        if (p < 0) return 8'h00;
        return (p == resp_delay) ? resp_val : 8'hFF;
    endfunction

    // Behavioural byte shifter: SHIFT clocks per byte, idle asserted a few clocks after the last byte.
    initial begin
        bit sh_busy;
        int sh_cnt, idle_dly;
        sh_busy = 0; sh_cnt = 0; idle_dly = 0;
        bus.spi_byte_done = 1'b0;
        bus.spi_rx_byte   = 8'hFF;
        bus.spi_idle      = 1'b1;
        forever begin
            @(negedge clock);
            bus.spi_byte_done = 1'b0;
            if (bus.cs_n) k = 0;
            if (reset) begin
                sh_busy = 0; idle_dly = 0; bus.spi_idle = 1'b1; k = 0;
            end else if (sh_busy) begin
                sh_cnt--;
                if (sh_cnt == 0) begin
                    bus.spi_byte_done = 1'b1;
                    bus.spi_rx_byte   = rx_for(k);
                    k++;
                    sh_busy  = 0;
                    idle_dly = 3;
                end
            end else if (bus.spi_tx_valid) begin
                txq.push_back(bus.spi_tx_byte);
                sh_busy = 1; sh_cnt = SHIFT; idle_dly = 0;
                bus.spi_idle = 1'b0;
            end else if (idle_dly > 0) begin
                idle_dly--;
                if (idle_dly == 0) bus.spi_idle = 1'b1;
            end
        end
    end

    always @(posedge clock) pe_idle = bus.spi_idle;
    always @(negedge clock) begin
        if (bus.done) done_cnt++;
        if (!reset && !prev_cs && bus.cs_n && !pe_idle) cs_viol++;
        prev_cs = bus.cs_n;
    end

    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int delay,
                           input logic [7:0] rv, input logic [7:0] b5, input bit poke, input string tag);
        logic [7:0] expq[$];
        logic [39:0] m;
        logic [7:0] exp_r1, r1_hold;
        int npoll, n, d0, bad;
        bit poked, exp_to;
        m = {2'b01, idx, arg};
        for (int i = 0; i < LEAD; i++) expq.push_back(8'hFF);
        for (int i = 4; i >= 0; i--) expq.push_back(m[8*i +: 8]);
        expq.push_back((b5 != 8'h00) ? b5 : {crc_ref(m), 1'b1});
        if (delay >= 0 && delay < MAXP) begin
            npoll = delay + 1; exp_r1 = rv; exp_to = 1'b0;
        end else begin
            npoll = MAXP; exp_r1 = 8'hFF; exp_to = 1'b1;
        end
        for (int i = 0; i <= npoll; i++) expq.push_back(8'hFF);
        txq.delete();
        resp_delay = delay; resp_val = rv; d0 = done_cnt; poked = 0;
        @(negedge clock);
        bus.cmd_start = 1'b1; bus.cmd_index = idx; bus.cmd_arg = arg;
        @(negedge clock);
        bus.cmd_start = 1'b0; bus.cmd_index = 6'($urandom); bus.cmd_arg = $urandom;
        chk({tag, " busy_after_start"}, bus.busy, 1'b1);
        n = 0;
        while (!bus.done && n < 3000) begin
            @(negedge clock);
            n++;
            if (poke && k == 3 && !poked) begin
                bus.cmd_start = 1'b1; bus.cmd_index = 6'd2; poked = 1;
            end else bus.cmd_start = 1'b0;
        end
        if (!bus.done) begin
            chk({tag, " done_seen"}, 1'b0, 1'b1);
            return;
        end
        if (poke) bus.cmd_start = 1'b1;
        chk({tag, " r1"}, bus.r1, exp_r1);
        chk({tag, " timeout"}, bus.timeout, exp_to);
        chk({tag, " cs_n_at_done"}, bus.cs_n, 1'b1);
        chk({tag, " busy_at_done"}, bus.busy, 1'b1);
        bad = -1;
        if (txq.size() != expq.size()) bad = 1000 + txq.size();
        else for (int i = 0; i < expq.size(); i++) if (bad < 0 && txq[i] !== expq[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            if (bad >= 1000) $display("FAIL %s tx_bytes: got %0d bytes expected %0d", tag, txq.size(), expq.size());
            else $display("FAIL %s tx_bytes: byte %0d got %0h expected %0h", tag, bad, txq[bad], expq[bad]);
        end
        r1_hold = bus.r1;
        @(negedge clock);
        bus.cmd_start = 1'b0;
        chk({tag, " busy_after_done"}, bus.busy, 1'b0);
        chk({tag, " done_pulse_len"}, bus.done, 1'b0);
        chk({tag, " done_count"}, done_cnt - d0, 1);
        if (poke) begin
            repeat (40) @(negedge clock);
            chk({tag, " no_second_frame"}, txq.size(), expq.size());
            chk({tag, " idle_cs_n"}, bus.cs_n, 1'b1);
            chk({tag, " r1_held"}, bus.r1, r1_hold);
        end
    endtask

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        int          delay;
        logic [7:0]  rv;
        logic [7:0]  b5;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int n;
        tbl[0] = '{6'd0,  32'h0000_0000, 2,      8'h01, 8'h95};
        tbl[1] = '{6'd8,  32'h0000_01AA, 0,      8'h01, 8'h87};
        tbl[2] = '{6'd55, 32'h0000_0000, MAXP,   8'h00, 8'h00};
        tbl[3] = '{6'd17, 32'h0000_1234, MAXP-1, 8'h05, 8'h00};
        tbl[4] = '{6'd58, 32'hDEAD_BEEF, -1,     8'h00, 8'h00};
        bus.cmd_start = 1'b0; bus.cmd_index = '0; bus.cmd_arg = '0;

        repeat (2) @(negedge clock);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst done", bus.done, 1'b0);
        chk("rst r1", bus.r1, 8'hFF);
        chk("rst timeout", bus.timeout, 1'b0);
        chk("rst cs_n", bus.cs_n, 1'b1);
        chk("rst tx_valid", bus.spi_tx_valid, 1'b0);
        chk("rst tx_byte", bus.spi_tx_byte, 8'hFF);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 5; i++)
            run_cmd(tbl[i].idx, tbl[i].arg, tbl[i].delay, tbl[i].rv, tbl[i].b5, 1'b0, $sformatf("vec%0d", i));

        run_cmd(6'd8, 32'h0000_01AA, 1, 8'h01, 8'h87, 1'b1, "ignore_start");

        // Abort after lead + B0..B2 have gone out.
        txq.delete(); resp_delay = 0; resp_val = 8'h00;
        @(negedge clock);
        bus.cmd_start = 1'b1; bus.cmd_index = 6'd17; bus.cmd_arg = 32'h0000_0200;
        @(negedge clock);
        bus.cmd_start = 1'b0;
        n = 0;
        while (k < 4 && n < 500) begin @(negedge clock); n++; end
        chk("abort reached_B2", (k >= 4), 1'b1);
        reset = 1'b1;
        #1;
        chk("abort cs_n", bus.cs_n, 1'b1);
        chk("abort tx_valid", bus.spi_tx_valid, 1'b0);
        chk("abort busy", bus.busy, 1'b0);
        chk("abort done", bus.done, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        run_cmd(6'd17, 32'h0000_0200, 1, 8'h00, 8'h00, 1'b0, "after_abort");

        for (int i = 0; i < 200; i++)
            run_cmd(6'($urandom_range(0, 63)), $urandom, $urandom_range(0, MAXP - 1),
                    8'($urandom_range(0, 127)), 8'h00, 1'b0, $sformatf("rnd%0d", i));

        chk("cs_n_rise_only_when_idle", cs_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
